// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register pending-write scoreboard for load-use hazard detection.
module regfile_mp_sb #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_rd,
    input  logic                flush,
    output logic [NRD-1:0]      rbusy
);

    localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    logic [AW-1:0]   wa [NWR];
    logic [XLEN-1:0] wd [NWR];
    logic [AW-1:0]   ra [NRD];

    for (genvar k = 0; k < NWR; k++) begin : g_wr_unpack
        assign wa[k] = waddr[k*AW +: AW];
        assign wd[k] = wdata[k*XLEN +: XLEN];
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd_unpack
        assign ra[j] = raddr[j*AW +: AW];
    end

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREG_L;
    endfunction

    // An address that can hold state: inside the file and not a hardwired r0.
    function automatic logic writable(input logic [AW-1:0] a);
        return in_range(a) && !(ZERO_R0 != 0 && a == '0);
    endfunction

    // NOTE: the whole array is reset on purpose; reset contents are
    // architecturally visible and must read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            // NOTE: non-blocking updates in ascending port order make the last
            // (highest-index) port win a same-address collision.
            for (int k = 0; k < NWR; k++) begin
                if (wen[k] && writable(wa[k])) regs[wa[k]] <= wd[k];
            end
        end
    end

    // Set is applied after clear so a back-to-back load to the same rd stays pending.
    always_comb begin
        pend_nxt = pend;
        if (wen[NWR-1] && in_range(wa[NWR-1])) pend_nxt[wa[NWR-1]] = 1'b0;
        if (alloc_en && writable(alloc_rd))    pend_nxt[alloc_rd]  = 1'b1;
        if (flush)                             pend_nxt            = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= pend_nxt;
    end

    // NOTE: every output bit gets a default first so no path infers a latch.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            if (in_range(ra[j])) begin
                rdata[j*XLEN +: XLEN] = regs[ra[j]];
                rbusy[j]              = pend[ra[j]];
            end
            if (BYPASS != 0) begin
                for (int k = 0; k < NWR; k++) begin
                    if (wen[k] && writable(wa[k]) && wa[k] == ra[j])
                        rdata[j*XLEN +: XLEN] = wd[k];
                end
                if (wen[NWR-1] && wa[NWR-1] == ra[j]) rbusy[j] = 1'b0;
            end
            if (ZERO_R0 != 0 && ra[j] == '0) begin
                rdata[j*XLEN +: XLEN] = '0;
                rbusy[j]              = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a bypassing 2R/2W instance and a
// non-bypassing 3R/3W instance share clock and reset.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  a_wen;
    logic [9:0]  a_waddr;
    logic [63:0] a_wdata;
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic        a_alloc_en;
    logic [4:0]  a_alloc_rd;
    logic        a_flush;
    logic [1:0]  a_rbusy;

    logic [2:0]  b_wen;
    logic [14:0] b_waddr;
    logic [95:0] b_wdata;
    logic [14:0] b_raddr;
    logic [95:0] b_rdata;
    logic        b_alloc_en;
    logic [4:0]  b_alloc_rd;
    logic        b_flush;
    logic [2:0]  b_rbusy;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp_sb dut_a (
        .clk(clk), .rst_n(rst_n),
        .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata),
        .raddr(a_raddr), .rdata(a_rdata),
        .alloc_en(a_alloc_en), .alloc_rd(a_alloc_rd),
        .flush(a_flush), .rbusy(a_rbusy)
    );

    regfile_mp_sb #(.BYPASS(0), .NRD(3), .NWR(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata),
        .raddr(b_raddr), .rdata(b_rdata),
        .alloc_en(b_alloc_en), .alloc_rd(b_alloc_rd),
        .flush(b_flush), .rbusy(b_rbusy)
    );

    task automatic a_idle();
        a_wen = '0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
        a_alloc_en = 1'b0; a_alloc_rd = '0; a_flush = 1'b0;
    endtask

    task automatic b_idle();
        b_wen = '0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
        b_alloc_en = 1'b0; b_alloc_rd = '0; b_flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a_raddr = {5'(31 - i), 5'(i)};
            b_raddr = {5'(i), 5'(31 - i), 5'(i)};
            #1;
            n_checks++;
            if (a_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_a_rdata r%0d: got %h expected 0", i, a_rdata); end
            n_checks++;
            if (a_rbusy !== 2'b00) begin n_fail++; $display("FAIL reset_a_rbusy r%0d: got %b expected 00", i, a_rbusy); end
            n_checks++;
            if (b_rdata !== 96'h0) begin n_fail++; $display("FAIL reset_b_rdata r%0d: got %h expected 0", i, b_rdata); end
            n_checks++;
            if (b_rbusy !== 3'b000) begin n_fail++; $display("FAIL reset_b_rbusy r%0d: got %b expected 000", i, b_rbusy); end
        end
        a_idle(); b_idle();
    endtask

    task automatic test_write_read();
        @(negedge clk);
        a_idle(); a_wen = 2'b01; a_waddr[4:0] = 5'd5; a_wdata[31:0] = 32'hDEADBEEF; a_raddr[4:0] = 5'd5;
        #1; n_checks++;
        if (a_rdata[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_r5: got %h expected deadbeef", a_rdata[31:0]); end
        @(negedge clk);
        a_idle(); a_raddr[4:0] = 5'd5;
        #1; n_checks++;
        if (a_rdata[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_r5: got %h expected deadbeef", a_rdata[31:0]); end
        @(negedge clk);
        a_idle(); a_wen = 2'b01; a_waddr[4:0] = 5'd0; a_wdata[31:0] = 32'h1234; a_raddr[4:0] = 5'd0;
        #1; n_checks++;
        if (a_rdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL r0_bypass: got %h expected 0", a_rdata[31:0]); end
        @(negedge clk);
        a_idle(); a_raddr[4:0] = 5'd0;
        #1; n_checks++;
        if (a_rdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL r0_read: got %h expected 0", a_rdata[31:0]); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        a_idle(); a_wen = 2'b11; a_waddr = {5'd7, 5'd7}; a_wdata = {32'h22, 32'h11}; a_raddr = {5'd7, 5'd7};
        #1; n_checks++;
        if (a_rdata !== {32'h22, 32'h22}) begin n_fail++; $display("FAIL collide_bypass: got %h expected both 22", a_rdata); end
        @(negedge clk);
        a_idle(); a_raddr[4:0] = 5'd7;
        #1; n_checks++;
        if (a_rdata[31:0] !== 32'h22) begin n_fail++; $display("FAIL collide_read: got %h expected 22", a_rdata[31:0]); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        a_idle(); a_alloc_en = 1'b1; a_alloc_rd = 5'd3; a_raddr[4:0] = 5'd3;
        #1; n_checks++;
        if (a_rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL alloc_not_yet: got %b expected 0", a_rbusy[0]); end
        @(negedge clk);
        a_idle(); a_raddr[4:0] = 5'd3;
        #1; n_checks++;
        if (a_rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL alloc_busy: got %b expected 1", a_rbusy[0]); end
        @(negedge clk);
        a_idle(); a_wen = 2'b10; a_waddr[9:5] = 5'd3; a_wdata[63:32] = 32'h55; a_raddr[4:0] = 5'd3;
        #1; n_checks++;
        if (a_rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL load_busy_bypass: got %b expected 0", a_rbusy[0]); end
        n_checks++;
        if (a_rdata[31:0] !== 32'h55) begin n_fail++; $display("FAIL load_data_bypass: got %h expected 55", a_rdata[31:0]); end
        @(negedge clk);
        a_idle(); a_raddr[4:0] = 5'd3;
        #1; n_checks++;
        if (a_rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL pend_cleared: got %b expected 0", a_rbusy[0]); end
        // An ALU-port write must not release a pending load destination.
        a_alloc_en = 1'b1; a_alloc_rd = 5'd3;
        @(negedge clk);
        a_idle(); a_wen = 2'b01; a_waddr[4:0] = 5'd3; a_wdata[31:0] = 32'h66; a_raddr[4:0] = 5'd3;
        #1; n_checks++;
        if (a_rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL alu_bypass_keeps_busy: got %b expected 1", a_rbusy[0]); end
        @(negedge clk);
        a_idle(); a_raddr[4:0] = 5'd3;
        #1; n_checks++;
        if (a_rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL alu_no_clear: got %b expected 1", a_rbusy[0]); end
        n_checks++;
        if (a_rdata[31:0] !== 32'h66) begin n_fail++; $display("FAIL alu_write_r3: got %h expected 66", a_rdata[31:0]); end
        a_wen = 2'b10; a_waddr[9:5] = 5'd3; a_wdata[63:32] = 32'h77;
        @(negedge clk);
        a_idle();
    endtask

    task automatic test_race_flush();
        @(negedge clk);
        a_idle(); a_alloc_en = 1'b1; a_alloc_rd = 5'd9;
        @(negedge clk);
        a_idle(); a_wen = 2'b10; a_waddr[9:5] = 5'd9; a_wdata[63:32] = 32'h99;
        a_alloc_en = 1'b1; a_alloc_rd = 5'd9; a_raddr[4:0] = 5'd9;
        #1; n_checks++;
        if (a_rbusy[0] !== 1'b0) begin n_fail++; $display("FAIL race_bypass_busy: got %b expected 0", a_rbusy[0]); end
        n_checks++;
        if (a_rdata[31:0] !== 32'h99) begin n_fail++; $display("FAIL race_bypass_data: got %h expected 99", a_rdata[31:0]); end
        @(negedge clk);
        a_idle(); a_raddr[4:0] = 5'd9;
        #1; n_checks++;
        if (a_rbusy[0] !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got %b expected 1", a_rbusy[0]); end
        @(negedge clk);
        a_idle(); a_flush = 1'b1; a_alloc_en = 1'b1; a_alloc_rd = 5'd4; a_raddr = {5'd4, 5'd9};
        #1; n_checks++;
        if (a_rbusy !== 2'b01) begin n_fail++; $display("FAIL flush_is_sync: got %b expected 01", a_rbusy); end
        @(negedge clk);
        a_idle(); a_raddr = {5'd4, 5'd9};
        #1; n_checks++;
        if (a_rbusy !== 2'b00) begin n_fail++; $display("FAIL flush_over_alloc: got %b expected 00", a_rbusy); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a_idle(); a_wen = 2'b01; a_waddr[4:0] = 5'd12; a_wdata[31:0] = 32'hCAFE;
        a_alloc_en = 1'b1; a_alloc_rd = 5'd11;
        @(negedge clk);
        a_idle(); a_raddr = {5'd11, 5'd12};
        #1; n_checks++;
        if (a_rdata[31:0] !== 32'hCAFE || a_rbusy[1] !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_state: got data %h busy %b expected cafe 1", a_rdata[31:0], a_rbusy[1]);
        end
        @(negedge clk);
        a_idle(); a_wen = 2'b01; a_waddr[4:0] = 5'd10; a_wdata[31:0] = 32'hAAAA;
        a_alloc_en = 1'b1; a_alloc_rd = 5'd13; a_raddr = {5'd11, 5'd12};
        #2 rst_n = 1'b0;
        #1; n_checks++;
        if (a_rdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL async_regs: got %h expected 0", a_rdata[31:0]); end
        n_checks++;
        if (a_rbusy[1] !== 1'b0) begin n_fail++; $display("FAIL async_pend: got %b expected 0", a_rbusy[1]); end
        @(negedge clk);
        a_idle(); rst_n = 1'b1; a_raddr = {5'd13, 5'd10};
        #1; n_checks++;
        if (a_rdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL dropped_write: got %h expected 0", a_rdata[31:0]); end
        n_checks++;
        if (a_rbusy[1] !== 1'b0) begin n_fail++; $display("FAIL dropped_alloc: got %b expected 0", a_rbusy[1]); end
        a_idle();
    endtask

    task automatic test_no_bypass();
        @(negedge clk);
        b_idle(); b_wen = 3'b001; b_waddr[4:0] = 5'd5; b_wdata[31:0] = 32'hDEADBEEF; b_raddr[4:0] = 5'd5;
        #1; n_checks++;
        if (b_rdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL nb_same_cycle_old: got %h expected 0", b_rdata[31:0]); end
        @(negedge clk);
        b_idle(); b_raddr[4:0] = 5'd5;
        #1; n_checks++;
        if (b_rdata[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL nb_read_r5: got %h expected deadbeef", b_rdata[31:0]); end
        b_wen = 3'b010; b_waddr[9:5] = 5'd0; b_wdata[63:32] = 32'h1234;
        @(negedge clk);
        b_idle(); b_raddr[4:0] = 5'd0;
        #1; n_checks++;
        if (b_rdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL nb_r0_read: got %h expected 0", b_rdata[31:0]); end
        b_wen = 3'b011; b_waddr = {5'd0, 5'd7, 5'd7}; b_wdata = {32'h0, 32'h22, 32'h11}; b_raddr[14:10] = 5'd7;
        #1; n_checks++;
        if (b_rdata[95:64] !== 32'h0) begin n_fail++; $display("FAIL nb_collide_same_cycle: got %h expected 0", b_rdata[95:64]); end
        @(negedge clk);
        b_idle(); b_raddr[14:10] = 5'd7;
        #1; n_checks++;
        if (b_rdata[95:64] !== 32'h22) begin n_fail++; $display("FAIL nb_collide_read: got %h expected 22", b_rdata[95:64]); end
        b_wen = 3'b111; b_waddr = {5'd8, 5'd8, 5'd8}; b_wdata = {32'h33, 32'h22, 32'h11};
        @(negedge clk);
        b_idle(); b_raddr[9:5] = 5'd8;
        #1; n_checks++;
        if (b_rdata[63:32] !== 32'h33) begin n_fail++; $display("FAIL nb_collide3_read: got %h expected 33", b_rdata[63:32]); end
        b_alloc_en = 1'b1; b_alloc_rd = 5'd3;
        @(negedge clk);
        b_idle(); b_raddr[9:5] = 5'd3;
        #1; n_checks++;
        if (b_rbusy[1] !== 1'b1) begin n_fail++; $display("FAIL nb_alloc_busy: got %b expected 1", b_rbusy[1]); end
        b_wen = 3'b010; b_waddr[9:5] = 5'd3; b_wdata[63:32] = 32'h44;
        @(negedge clk);
        b_idle(); b_raddr[9:5] = 5'd3;
        #1; n_checks++;
        if (b_rbusy[1] !== 1'b1) begin n_fail++; $display("FAIL nb_port1_no_clear: got %b expected 1", b_rbusy[1]); end
        n_checks++;
        if (b_rdata[63:32] !== 32'h44) begin n_fail++; $display("FAIL nb_port1_write: got %h expected 44", b_rdata[63:32]); end
        b_wen = 3'b100; b_waddr[14:10] = 5'd3; b_wdata[95:64] = 32'h55;
        #1; n_checks++;
        if (b_rbusy[1] !== 1'b1) begin n_fail++; $display("FAIL nb_load_busy_same_cycle: got %b expected 1", b_rbusy[1]); end
        n_checks++;
        if (b_rdata[63:32] !== 32'h44) begin n_fail++; $display("FAIL nb_load_data_same_cycle: got %h expected 44", b_rdata[63:32]); end
        @(negedge clk);
        b_idle(); b_raddr[9:5] = 5'd3;
        #1; n_checks++;
        if (b_rbusy[1] !== 1'b0) begin n_fail++; $display("FAIL nb_load_clears: got %b expected 0", b_rbusy[1]); end
        n_checks++;
        if (b_rdata[63:32] !== 32'h55) begin n_fail++; $display("FAIL nb_load_data: got %h expected 55", b_rdata[63:32]); end
        b_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        a_idle();
        b_idle();
        test_reset();
        test_write_read();
        test_collision();
        test_scoreboard();
        test_race_flush();
        test_async_reset();
        test_no_bypass();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
